trip_recorder: RTL and testbench
================================

// Module: trip_recorder
// PURPOSE
//  Producer side of the VGA record display path. Counts distance-unit pulses during a trip
//  into a 7-digit BCD accumulator. At trip end, commits the total into the record registers
//  led1..led7 and raises has_record. vga_record reads these registers to render the
//  "record" row.
// PARAMETERS
//  KEEP_MAX  1  1: commit only if new trip total > stored record (or no record yet);
//               0: every trip overwrites the record
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  trip_start    in   1   1-cycle pulse: begin a new trip
//  trip_end      in   1   1-cycle pulse: finish the trip and commit its total
//  inc           in   1   1-cycle pulse: +1 distance unit
//  clear_record  in   1   1-cycle pulse: erase the stored record
//  live          out  28  current trip total, packed BCD; [27:24] is the most significant digit
//  busy          out  1   1 while a trip is running (state RUN)
//  overflow      out  1   sticky per trip: accumulator saturated at 9999999
//  led1..led7    out  4   record digits, BCD; led1 = least significant, led7 = most significant
//  has_record    out  1   1 when led1..led7 hold a valid record
// BEHAVIOUR
//  Reset: state=IDLE, live=0, busy=0, overflow=0, led1..led7=0, has_record=0.
//    Reset mid-trip discards the trip.
//  All outputs are registered. States: IDLE, RUN, SAVE.
//  IDLE:
//    - trip_start -> live<=0, overflow<=0, next=RUN.
//    - inc and trip_end are ignored.
//  RUN:
//    - inc -> BCD +1 with a ripple carry across all 7 digits (digit 9 -> 0, carry up).
//    - At 9999999, inc holds the value and sets overflow.
//    - trip_end -> next=SAVE. An inc in the same cycle IS counted before the save.
//    - trip_start in RUN is ignored (no restart).
//  SAVE (exactly 1 cycle):
//    - Commit condition: KEEP_MAX==0, or has_record==0, or live > {led7..led1}.
//      The comparison is unsigned over the packed 28-bit BCD (valid BCD orders correctly).
//    - If the condition holds: led1..led7 <= live digits, has_record <= 1.
//    - next=IDLE; inc is ignored.
//  Latency: trip_end sampled in cycle N -> SAVE in cycle N+1 -> new record visible in N+2.
//  clear_record (any state): led1..led7<=0 and has_record<=0 on the next edge.
//    - Clear in the SAVE cycle wins over the commit.
//    - Clear does not affect live, busy or the state.
//  Equal totals with KEEP_MAX=1: no commit (strictly greater only).
//  trip_start and trip_end in the same IDLE cycle: start taken, end ignored.
//  live holds its last value in IDLE until the next trip_start.
// TESTING
//  1. rst, then trip_start, 123 inc pulses, trip_end
//     -> cycle N+2: led3..led1 = 1,2,3, led7..led4 = 0, has_record=1, busy=0.
//  2. KEEP_MAX=1, record 123; trip of 50 incs -> record unchanged (123);
//     trip of 200 -> record 200; trip of exactly 200 -> no commit.
//  3. Carry chain: preload 0999999 via 999999 incs, 1 more inc -> live=0x1000000.
//     Saturation: at 9999999, 2 incs -> value held, overflow=1.
//  4. inc in the same cycle as trip_end -> committed total includes it (e.g. 10 incs + 1 -> 11).
//  5. clear_record asserted during the SAVE cycle -> has_record=0 and leds=0 at N+2.
//     Later trip of 5 -> record=5 regardless of KEEP_MAX.
//  6. rst mid-RUN after 40 incs -> all outputs 0 next cycle;
//     trip_end afterwards is ignored (has_record stays 0).

Source files
------------

// File: rtl/trip_recorder.sv
// Trip distance recorder: counts distance pulses into a 7-digit BCD total and
// keeps the best (or last) trip total in the record registers for the display.
module trip_recorder #(
  parameter bit KEEP_MAX = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       trip_start_i,
  input  logic       trip_end_i,
  input  logic       inc_i,
  input  logic       clear_record_i,
  output logic [27:0] live_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic [3:0] led1_o,
  output logic [3:0] led2_o,
  output logic [3:0] led3_o,
  output logic [3:0] led4_o,
  output logic [3:0] led5_o,
  output logic [3:0] led6_o,
  output logic [3:0] led7_o,
  output logic       has_record_o
);

  typedef enum logic [1:0] {IDLE, RUN, SAVE} state_e;

  localparam logic [27:0] BCD_MAX = 28'h9999999;

  state_e      state_q, state_d;
  logic [27:0] live_q, live_d;
  logic [27:0] rec_q, rec_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        has_q, has_d;

  // Ripple-carry BCD +1: each digit wraps 9->0 and passes the carry upward.
  function automatic logic [27:0] bcd_inc(input logic [27:0] v);
    logic [27:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    rec_d   = rec_q;
    ovf_d   = ovf_q;
    has_d   = has_q;
    unique case (state_q)
      IDLE: begin
        if (trip_start_i) begin
          live_d  = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (inc_i) begin
          if (live_q == BCD_MAX) ovf_d = 1'b1;
          else                   live_d = bcd_inc(live_q);
        end
        if (trip_end_i) state_d = SAVE;
      end
      SAVE: begin
        // Packed BCD compares correctly as a plain unsigned number.
        if (!KEEP_MAX || !has_q || (live_q > rec_q)) begin
          rec_d = live_q;
          has_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clearing the record overrides a commit happening in the same cycle.
    if (clear_record_i) begin
      rec_d = '0;
      has_d = 1'b0;
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      live_q  <= '0;
      rec_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      has_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      rec_q   <= rec_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      has_q   <= has_d;
    end
  end

  assign live_o       = live_q;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;
  assign has_record_o = has_q;
  assign led1_o       = rec_q[3:0];
  assign led2_o       = rec_q[7:4];
  assign led3_o       = rec_q[11:8];
  assign led4_o       = rec_q[15:12];
  assign led5_o       = rec_q[19:16];
  assign led6_o       = rec_q[23:20];
  assign led7_o       = rec_q[27:24];

endmodule

// File: tb/tb_trip_recorder.sv
// Directed bench for trip_recorder: a KEEP_MAX=1 unit under full check and a
// KEEP_MAX=0 unit sharing the same stimulus to confirm unconditional overwrite.
module tb_trip_recorder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tripStart = 1'b0;
  logic tripEnd = 1'b0;
  logic inc = 1'b0;
  logic clearRecord = 1'b0;

  logic [27:0] live1, live0;
  logic        busy1, busy0, ovf1, ovf0, has1, has0;
  logic [3:0]  l1a, l2a, l3a, l4a, l5a, l6a, l7a;
  logic [3:0]  l1b, l2b, l3b, l4b, l5b, l6b, l7b;
  logic [27:0] rec1, rec0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  trip_recorder #(.KEEP_MAX(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .trip_start_i(tripStart), .trip_end_i(tripEnd),
    .inc_i(inc), .clear_record_i(clearRecord), .live_o(live1), .busy_o(busy1),
    .overflow_o(ovf1), .led1_o(l1a), .led2_o(l2a), .led3_o(l3a), .led4_o(l4a),
    .led5_o(l5a), .led6_o(l6a), .led7_o(l7a), .has_record_o(has1)
  );

  trip_recorder #(.KEEP_MAX(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .trip_start_i(tripStart), .trip_end_i(tripEnd),
    .inc_i(inc), .clear_record_i(clearRecord), .live_o(live0), .busy_o(busy0),
    .overflow_o(ovf0), .led1_o(l1b), .led2_o(l2b), .led3_o(l3b), .led4_o(l4b),
    .led5_o(l5b), .led6_o(l6b), .led7_o(l7b), .has_record_o(has0)
  );

  assign rec1 = {l7a, l6a, l5a, l4a, l3a, l2a, l1a};
  assign rec0 = {l7b, l6b, l5b, l4b, l3b, l2b, l1b};

  // Drives one cycle of inputs, lets the edge take them, then samples 1ns later.
  task automatic applyStimulus(input logic s, input logic e, input logic i, input logic c);
    tripStart   = s;
    tripEnd     = e;
    inc         = i;
    clearRecord = c;
    @(posedge clk);
    #1;
    tripStart   = 1'b0;
    tripEnd     = 1'b0;
    inc         = 1'b0;
    clearRecord = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [27:0] got, input logic [27:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic runTrip(input int n, input logic incAtEnd);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, incAtEnd, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("reset_live", live1, 28'h0);
    checkOutput("reset_busy", {27'b0, busy1}, 28'h0);
    checkOutput("reset_ovf", {27'b0, ovf1}, 28'h0);
    checkOutput("reset_has", {27'b0, has1}, 28'h0);
    checkOutput("reset_rec", rec1, 28'h0);

    // Idle ignores inc and trip_end.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_ignore_has", {27'b0, has1}, 28'h0);
    checkOutput("idle_ignore_live", live1, 28'h0);

    // First trip of 123 units.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy_run", {27'b0, busy1}, 28'h1);
    repeat (123) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_live", live1, 28'h0000123);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_busy_save", {27'b0, busy1}, 28'h0);
    checkOutput("t1_has_n1", {27'b0, has1}, 28'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_rec", rec1, 28'h0000123);
    checkOutput("t1_led3", {24'b0, l3a}, 28'h1);
    checkOutput("t1_led1", {24'b0, l1a}, 28'h3);
    checkOutput("t1_has", {27'b0, has1}, 28'h1);
    checkOutput("t1_live_hold", live1, 28'h0000123);

    // Keep-max behaviour; the KEEP_MAX=0 unit always overwrites.
    runTrip(50, 1'b0);
    checkOutput("t2_small_kept", rec1, 28'h0000123);
    checkOutput("t2_overwrite_k0", rec0, 28'h0000050);
    runTrip(200, 1'b0);
    checkOutput("t2_bigger", rec1, 28'h0000200);
    runTrip(199, 1'b0);
    checkOutput("t2_199_kept", rec1, 28'h0000200);
    runTrip(200, 1'b0);
    checkOutput("t2_equal_kept", rec1, 28'h0000200);

    // inc coinciding with trip_end is counted.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_cleared", {27'b0, has1}, 28'h0);
    runTrip(10, 1'b1);
    checkOutput("t4_rec", rec1, 28'h0000011);
    checkOutput("t4_has", {27'b0, has1}, 28'h1);

    // Start+end together in IDLE: start wins; start in RUN does not restart.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("se_busy", {27'b0, busy1}, 28'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_ignored", live1, 28'h0000002);

    // Carry chain and saturation, preloading the accumulator by force.
    force dut1.live_q = 28'h0999999;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    release dut1.live_q;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_carry", live1, 28'h1000000);
    checkOutput("t3_no_ovf", {27'b0, ovf1}, 28'h0);
    force dut1.live_q = 28'h9999999;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    release dut1.live_q;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_sat_live", live1, 28'h9999999);
    checkOutput("t3_sat_ovf", {27'b0, ovf1}, 28'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_rec", rec1, 28'h9999999);
    checkOutput("t3_ovf_sticky", {27'b0, ovf1}, 28'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_ovf_cleared", {27'b0, ovf1}, 28'h0);
    checkOutput("t3_live_cleared", live1, 28'h0);

    // Clear in the SAVE cycle beats the commit.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_has", {27'b0, has1}, 28'h0);
    checkOutput("t5_rec", rec1, 28'h0);
    checkOutput("t5_live_kept", live1, 28'h0000003);
    runTrip(5, 1'b0);
    checkOutput("t5_rec5", rec1, 28'h0000005);
    checkOutput("t5_rec5_k0", rec0, 28'h0000005);

    // Reset mid-trip discards everything.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (40) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_live40", live1, 28'h0000040);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("t6_live", live1, 28'h0);
    checkOutput("t6_busy", {27'b0, busy1}, 28'h0);
    checkOutput("t6_has", {27'b0, has1}, 28'h0);
    checkOutput("t6_rec", rec1, 28'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_end_ignored", {27'b0, has1}, 28'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
